// File: rtl/scope_pkg.sv
// ============================================================================
// Module  : scope_pkg
// Brief   : Shared types, default sizes and threshold helper for the scope
//           trigger/capture block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_READY     = 3'd4
    } state_e;

    localparam int DEF_DATA_W       = 12;
    localparam int DEF_DEPTH        = 640;
    localparam int DEF_AUTO_TIMEOUT = 4096;

    // Adds or subtracts with one guard bit, clamping to [0, 2^width-1].
    function automatic logic [31:0] sat_addsub(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sub,
        input int          width
    );
        logic [32:0] res;
        logic [32:0] max_val;
        max_val = (33'd1 << width) - 33'd1;
        res     = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        if (sub && res[32]) begin
            return 32'd0;
        end
        if (!sub && (res > max_val)) begin
            return max_val[31:0];
        end
        return res[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/scope_sample_ram.sv
// ============================================================================
// Module  : scope_sample_ram
// Brief   : Simple dual-port frame buffer, synchronous write, registered read.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module scope_sample_ram
    import scope_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam logic [ADDR_W:0] DEPTH_EXT = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Addresses past the frame width read as zero rather than aliasing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr_i} < DEPTH_EXT) begin
            rd_data_q <= mem[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/scope_trigger_capture.sv
// ============================================================================
// Module  : scope_trigger_capture
// Brief   : Level trigger with hysteresis and single-frame capture for the
//           VGA scope. Optional forced trigger via macro AUTO_TRIGGER_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module scope_trigger_capture
    import scope_pkg::*;
#(
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int DEPTH        = DEF_DEPTH,
    parameter  int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_stb,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] trig_hyst,
    input  logic              trig_rising,
    input  logic              arm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              capture_busy,
    output logic              frame_ready,
    output logic              triggered
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((DEPTH < 2) || (DATA_W > 32) || (AUTO_TIMEOUT < 1)) begin : g_param_check
        $error("scope_trigger_capture: unsupported parameter set");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic              busy_q;
    logic              ready_q;
    logic              trig_q;

    logic [DATA_W-1:0] lo_thr;
    logic [DATA_W-1:0] hi_thr;
    logic              arm_cond;
    logic              arm_accept;
    logic              real_hit;
    logic              force_hit;
    logic              start_cap;
    logic              frame_real;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    assign lo_thr = DATA_W'(sat_addsub(32'(trig_level), 32'(trig_hyst), 1'b1, DATA_W));
    assign hi_thr = DATA_W'(sat_addsub(32'(trig_level), 32'(trig_hyst), 1'b0, DATA_W));

    assign arm_cond   = trig_rising ? (sample_in < lo_thr) : (sample_in > hi_thr);
    assign arm_accept = arm && ((state_q == ST_IDLE) || (state_q == ST_READY));
    assign real_hit   = (state_q == ST_WAIT_TRIG) && sample_stb &&
                        (trig_rising ? (sample_in >= trig_level) : (sample_in <= trig_level));
    assign start_cap  = real_hit || force_hit;

`ifdef AUTO_TRIGGER_EN
    localparam int              CNT_W    = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_TIMEOUT - 1);

    logic [CNT_W-1:0] strobe_cnt_q;
    logic             real_frame_q;
    logic             hunting;

    assign hunting    = (state_q == ST_ARM) || (state_q == ST_WAIT_TRIG);
    assign force_hit  = hunting && sample_stb && !real_hit && (strobe_cnt_q == CNT_LAST);
    assign frame_real = real_frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_cnt_q <= '0;
            real_frame_q <= 1'b0;
        end else begin
            if (arm_accept) begin
                strobe_cnt_q <= '0;
            end else if (hunting && sample_stb) begin
                strobe_cnt_q <= strobe_cnt_q + CNT_W'(1);
            end
            if (start_cap) begin
                real_frame_q <= real_hit;
            end
        end
    end
`else
    assign force_hit  = 1'b0;
    assign frame_real = 1'b1;
`endif

    // The trigger strobe itself lands at address 0, so capture spans DEPTH strobes.
    assign wr_en    = start_cap || ((state_q == ST_CAPTURE) && sample_stb);
    assign wr_addr  = (state_q == ST_CAPTURE) ? wr_ptr_q : '0;
    assign wr_ptr_d = wr_ptr_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (arm) begin
                        state_q <= ST_ARM;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        trig_q  <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (start_cap) begin
                        state_q  <= ST_CAPTURE;
                        wr_ptr_q <= ADDR_W'(1);
                    end else if (sample_stb && arm_cond) begin
                        state_q <= ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (start_cap) begin
                        state_q  <= ST_CAPTURE;
                        wr_ptr_q <= ADDR_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (sample_stb) begin
                        if (wr_ptr_q == LAST_ADDR) begin
                            state_q  <= ST_READY;
                            wr_ptr_q <= '0;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            trig_q   <= frame_real;
                        end else begin
                            wr_ptr_q <= wr_ptr_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    scope_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (sample_in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign capture_busy = busy_q;
    assign frame_ready  = ready_q;
    assign triggered    = trig_q;

endmodule

`default_nettype wire

// File: tb/tb_scope_trigger_capture.sv
// ============================================================================
// Module  : tb_scope_trigger_capture
// Brief   : Scoreboard bench for scope_trigger_capture (both macro builds).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scope_trigger_capture;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 640;
    localparam int ADDR_W = 10;
`ifdef AUTO_TRIGGER_EN
    localparam bit AUTO   = 1'b1;
    localparam int TB_TO  = 16;
`else
    localparam bit AUTO   = 1'b0;
    localparam int TB_TO  = 4096;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_stb = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [DATA_W-1:0] trig_level = '0;
    logic [DATA_W-1:0] trig_hyst = '0;
    logic              trig_rising = 1'b1;
    logic              arm = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              capture_busy;
    logic              frame_ready;
    logic              triggered;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    scope_trigger_capture #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .AUTO_TIMEOUT (TB_TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_stb   (sample_stb),
        .sample_in    (sample_in),
        .trig_level   (trig_level),
        .trig_hyst    (trig_hyst),
        .trig_rising  (trig_rising),
        .arm          (arm),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .capture_busy (capture_busy),
        .frame_ready  (frame_ready),
        .triggered    (triggered)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench on a falling edge.
    task automatic stb(input logic [DATA_W-1:0] v, input int gap, input bit push);
        sample_in  = v;
        sample_stb = 1'b1;
        if (push) exp_q.push_back(v);
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic busy, input logic rdy, input logic trg);
        check_val({tag, "_busy"},  32'(capture_busy), 32'(busy));
        check_val({tag, "_ready"}, 32'(frame_ready),  32'(rdy));
        check_val({tag, "_trig"},  32'(triggered),    32'(trg));
    endtask

    task automatic read_frame(input string tag);
        logic [31:0] exp;
        check_val({tag, "_sb_size"}, 32'(exp_q.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            @(negedge clk);
            exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
            check_val($sformatf("%s_rd%0d", tag, i), 32'(rd_data), exp);
        end
        exp_q.delete();
    endtask

    initial begin
        // ---------------- reset state
        repeat (3) @(negedge clk);
        check_val("rst_rd_data", 32'(rd_data), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- test 1: rising trigger on a slow ramp
        trig_level = 12'd2048; trig_hyst = 12'd64; trig_rising = 1'b1;
        pulse_arm();
        check_flags("t1_armed", 1'b1, 1'b0, 1'b0);
        for (int v = 0; v < 2688; v++) begin
            if (AUTO && v > 0 && v < 2040) continue;
            if (v == 2687) begin
                check_flags("t1_pre_last", 1'b1, 1'b0, 1'b0);
                stb(12'(v), 0, 1'b1);
                check_flags("t1_done", 1'b0, 1'b1, 1'b1);
            end else begin
                stb(12'(v), 3, v >= 2048);
            end
        end
        read_frame("t1");
        rd_addr = 10'd640;
        @(negedge clk);
        check_val("t1_oob640", 32'(rd_data), 32'd0);
        rd_addr = 10'd1023;
        @(negedge clk);
        check_val("t1_oob1023", 32'(rd_data), 32'd0);

        // ---------------- test 2: falling trigger, noise before arming
        trig_level = 12'd1000; trig_hyst = 12'd100; trig_rising = 1'b0;
        pulse_arm();
        check_flags("t2_armed", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) stb((k % 2 == 1) ? 12'd1010 : 12'd990, 1, 1'b0);
        check_flags("t2_noise", 1'b1, 1'b0, 1'b0);
        for (int v = 4095; v >= 361; v--) begin
            if (AUTO && v < 4095 && v > 1008) continue;
            if (v == 361) begin
                check_flags("t2_pre_last", 1'b1, 1'b0, 1'b0);
                stb(12'(v), 0, 1'b1);
                check_flags("t2_done", 1'b0, 1'b1, 1'b1);
            end else begin
                stb(12'(v), 0, v <= 1000);
            end
        end
        @(negedge clk);
        read_frame("t2");

        // ---------------- test 4: arm pulse mid-capture is ignored
        trig_level = 12'd2048; trig_hyst = 12'd64; trig_rising = 1'b1;
        pulse_arm();
        stb(12'd0, 1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 300) begin
                rd_addr = 10'd5;
                pulse_arm();
                check_val("t4_rd_during_cap", 32'(rd_data), 32'd2110);
                check_flags("t4_arm_ignored", 1'b1, 1'b0, 1'b0);
            end
            if (i == DEPTH - 1) begin
                check_flags("t4_pre_last", 1'b1, 1'b0, 1'b0);
                stb(12'(2100 + 2 * i), 0, 1'b1);
                check_flags("t4_done", 1'b0, 1'b1, 1'b1);
            end else begin
                stb(12'(2100 + 2 * i), 1, 1'b1);
            end
        end
        read_frame("t4");

        // ---------------- test 5: reset mid-capture
        pulse_arm();
        check_flags("t5_arm_clears", 1'b1, 1'b0, 1'b0);
        stb(12'd0, 0, 1'b0);
        for (int i = 0; i < 200; i++) stb(12'(2500 + i), 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_rd_data", 32'(rd_data), 32'd0);
        check_flags("t5_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) stb(12'(i * 400), 1, 1'b0);
        check_flags("t5_idle", 1'b0, 1'b0, 1'b0);

        // ---------------- test 3: saturated low threshold never arms
        trig_level = 12'd10; trig_hyst = 12'd50; trig_rising = 1'b1;
        pulse_arm();
        for (int k = 0; k < 12; k++) stb((k % 3 == 0) ? 12'd0 : 12'(10 + k), 1, 1'b0);
        check_flags("t3_stuck_arm", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef AUTO_TRIGGER_EN
        // ---------------- test 6: forced trigger after the timeout
        trig_level = 12'd2048; trig_hyst = 12'd64; trig_rising = 1'b1;
        pulse_arm();
        for (int s = 1; s <= TB_TO + DEPTH - 1; s++) begin
            if (s == TB_TO + DEPTH - 1) begin
                check_flags("t6_pre_last", 1'b1, 1'b0, 1'b0);
                stb(12'd5, 0, 1'b1);
                check_flags("t6_done", 1'b0, 1'b1, 1'b0);
            end else begin
                stb(12'd5, 0, s >= TB_TO);
            end
        end
        read_frame("t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
